spi_arb: RTL

SPI_ARB -- requirements
Module: spi_arb

---
 rtl/spi_arb_pkg.sv | 26 ++
 rtl/spi_rr_pick.sv | 31 +++
 rtl/spi_arb.sv | 137 +++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the three-way SPI engine arbiter.
package spi_arb_pkg;

  localparam int NREQ    = 3;
  localparam int IDXW    = 2;
  localparam int REQ_SD  = 0;
  localparam int REQ_SW1 = 1;
  localparam int REQ_SW2 = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ACK   = 3'd4,
    ST_HOLD  = 3'd5,
    ST_GAP   = 3'd6
  } state_e;

  // Index following idx in round-robin order, wrapping after the last requester.
  function automatic logic [IDXW-1:0] rr_next(input logic [IDXW-1:0] idx);
    if (idx >= IDXW'(REQ_SW2)) return IDXW'(REQ_SD);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after start, wrapping.
module spi_rr_pick
  import spi_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] start,
  output logic            valid,
  output logic [IDXW-1:0] index
);

  logic [IDXW:0]   sum;
  logic [IDXW-1:0] cand;

  // Walk candidates from farthest to nearest so the nearest hit is assigned last.
  always_comb begin
    valid = 1'b0;
    index = start;
    sum   = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, start} + (IDXW+1)'(k);
      if (sum >= (IDXW+1)'(NREQ)) sum = sum - (IDXW+1)'(NREQ);
      cand = sum[IDXW-1:0];
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/spi_arb.sv
// Arbitrates three byte-stream requesters onto one shared SPI engine, with
// per-requester chip select, setup/hold/gap timing and a byte timeout.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] tx_byte,
  input  logic [NREQ-1:0]   last,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rx_byte,
  output logic [NREQ-1:0]   err,
  output logic              eng_start,
  output logic [7:0]        eng_tx,
  input  logic              eng_done,
  input  logic [7:0]        eng_rx,
  output logic [NREQ-1:0]   cs_n,
  output logic              busy,
  output logic [2:0]        state_debug
);

  localparam int CMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                             : ((CS_HOLD  > CS_GAP) ? CS_HOLD  : CS_GAP);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  state_e          state, nstate;
  logic [IDXW-1:0] g;          // granted requester, fixed for the whole transaction
  logic [IDXW-1:0] rr_start;   // where the next round-robin search begins
  logic [CW-1:0]   cnt;        // shared setup/hold/gap down-counter
  logic [TW-1:0]   tcnt;       // WAIT cycles elapsed for the current byte
  logic            last_q;
  logic [7:0]      eng_tx_q;
  logic [7:0]      rx_q;

  logic            pick_vld;
  logic [IDXW-1:0] pick_idx;
  logic            cnt_exp;
  logic            tmo;
  logic [7:0]      tx_sel;

  spi_rr_pick u_pick (
    .req   (req),
    .start (rr_start),
    .valid (pick_vld),
    .index (pick_idx)
  );

  assign cnt_exp = (cnt <= CW'(1));
  assign tmo     = (tcnt == TW'(TIMEOUT - 1));
  assign tx_sel  = tx_byte[{g, 3'b000} +: 8];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nstate;
  end

  // Next-state decode.
  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:  if (pick_vld) nstate = ST_SETUP;
      ST_SETUP: if (cnt_exp)  nstate = ST_ISSUE;
      ST_ISSUE: nstate = ST_WAIT;
      ST_WAIT:  if (eng_done) nstate = ST_ACK;
                else if (tmo) nstate = ST_HOLD;
      ST_ACK:   if (last_q)   nstate = ST_HOLD;
                else if (req[g]) nstate = ST_ISSUE;
                else          nstate = ST_HOLD;
      ST_HOLD:  if (cnt_exp)  nstate = ST_GAP;
      ST_GAP:   if (cnt_exp)  nstate = ST_IDLE;
      default:  nstate = ST_IDLE;
    endcase
  end

  // Grant, counters and byte latches; counters are reloaded on the way into each timed state.
  always_ff @(posedge clk) begin
    if (rst) begin
      g        <= '0;
      rr_start <= IDXW'(REQ_SD);
      cnt      <= '0;
      tcnt     <= '0;
      last_q   <= 1'b0;
      eng_tx_q <= '0;
      rx_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pick_vld) begin
          g   <= pick_idx;
          cnt <= CW'(CS_SETUP);
        end
        ST_SETUP: if (!cnt_exp) cnt <= cnt - 1'b1;
        ST_ISSUE: begin
          eng_tx_q <= tx_sel;
          last_q   <= last[g];
          tcnt     <= '0;
        end
        ST_WAIT: begin
          if (eng_done)  rx_q <= eng_rx;
          else if (tmo)  cnt  <= CW'(CS_HOLD);
          else           tcnt <= tcnt + 1'b1;
        end
        ST_ACK: if (last_q || !req[g]) cnt <= CW'(CS_HOLD);
        ST_HOLD: begin
          if (cnt_exp) cnt <= CW'(CS_GAP);
          else         cnt <= cnt - 1'b1;
        end
        ST_GAP: begin
          if (cnt_exp) rr_start <= rr_next(g);
          else         cnt      <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs; eng_tx shows the selected byte during ISSUE so it is valid with eng_start.
  always_comb begin
    busy        = (state != ST_IDLE);
    state_debug = state;
    eng_start   = (state == ST_ISSUE);
    eng_tx      = (state == ST_ISSUE) ? tx_sel : eng_tx_q;
    rx_byte     = rx_q;
    ack         = (state == ST_ACK) ? (NREQ'(1) << g) : '0;
    err         = (state == ST_WAIT && !eng_done && tmo) ? (NREQ'(1) << g) : '0;
    cs_n        = '1;
    if (state inside {ST_SETUP, ST_ISSUE, ST_WAIT, ST_ACK, ST_HOLD}) cs_n[g] = 1'b0;
  end

endmodule
